ahb_lite_master_pipe: RTL and testbench
=======================================

Name: ahb_lite_master_pipe

Overview:
- Parametrised, pipelined AHB-Lite master that replaces the single-shot IDLE/READ/WRITE master.
- Accepts requests from the core load/store stage over a valid/ready handshake and issues NONSEQ single transfers.
- Overlaps the address phase of transfer N+1 with the data phase of transfer N, honours HREADY wait states, and implements the two-cycle HRESP ERROR response.
- Returns in-order responses (read data plus error flag) to the core.

Parameters:
- ADDR_W, 32, HADDR and req_addr width.
- DATA_W, 32, HWDATA/HRDATA width; legal values 32 or 64.
- SIZE_W, 3, HSIZE and req_size width.

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  core has a transfer request.
- req_ready  out  1  master accepts the request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_size  in  SIZE_W  AHB HSIZE encoding.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse, in request order.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_error  out  1  transfer ended in ERROR or was cancelled.
- HADDR  out  ADDR_W  AHB address.
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only.
- HWRITE  out  1  AHB write.
- HSIZE  out  SIZE_W  AHB size.
- HWDATA  out  DATA_W  AHB write data.
- HRDATA  in  DATA_W  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB response, 0 = OKAY, 1 = ERROR.

Behaviour:
- Internal stages:
  - Address stage A: valid, addr, write, size, wdata, cancel.
  - Data stage D: valid, write, wdata.
- Reset (asynchronous, any time, including mid-transfer):
  - A, D and cancel are cleared; all in-flight transfers are lost with no response.
  - HTRANS=IDLE; HADDR, HWRITE, HSIZE, HWDATA = 0; rsp_valid=0, rsp_rdata=0, rsp_error=0.
- Bus drive:
  - HTRANS = NONSEQ when A.valid and not A.cancel, else IDLE.
  - HADDR, HWRITE and HSIZE come from A.
  - HWDATA comes from D.wdata and is held stable while HREADY=0.
- Handshake:
  - req_ready = (!A.valid || HREADY) && !error_pending.
  - A request is accepted on an edge where req_valid && req_ready, and is loaded into A.
  - Request fields must be stable while req_valid=1 and req_ready=0.
- Normal edge (HREADY=1, HRESP=0):
  - If D.valid, the data phase completes: next cycle rsp_valid=1, rsp_error=0, rsp_rdata = HRDATA for reads and 0 for writes.
  - D <= A; A <= the accepted request, or empty.
- Wait state (HREADY=0, HRESP=0): A, D and all bus outputs hold; rsp_valid=0.
- Latency and throughput:
  - With zero wait states, rsp_valid is asserted 2 cycles after the acceptance edge.
  - Back-to-back throughput is 1 transfer per cycle.
- ERROR, first cycle (D.valid, HRESP=1, HREADY=0):
  - At that edge: response rsp_valid=1, rsp_error=1, rsp_rdata=0 for D; D cleared.
  - If A.valid, A.cancel is set, which forces HTRANS=IDLE in the second cycle.
  - error_pending is set, so req_ready=0.
- ERROR, second cycle (HRESP=1, HREADY=1):
  - If A.cancel, the cancelled transfer is reported with rsp_valid=1, rsp_error=1.
  - A is cleared and error_pending is cleared.
  - No new request is accepted on this edge.
- Ordering: responses are strictly in request order. The two error responses occur on consecutive cycles, so rsp_valid never carries two transfers at once.
- Backpressure: rsp has none; the core must accept every rsp_valid.
- Size and alignment:
  - req_size must be ≤ log2(DATA_W/8).
  - Alignment is the requester's responsibility; the master passes address and size through unchanged.
- HRESP=1 while !D.valid is a slave protocol violation and is ignored.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE encodings (BYTE, HALF, WORD, DWORD).
  - HRESP codes (OKAY, ERROR).
  - A request struct typedef (write, addr, size, wdata).
- Single flat module; no sub-module is natural.
- The address and data stages are two register slices inside this module.

Test Plan:
- Read, zero wait: req read addr 0x100 accepted; slave HRDATA=0xDEADBEEF -> HTRANS=NONSEQ for 1 cycle; rsp_valid 2 cycles after acceptance with rsp_rdata=0xDEADBEEF, rsp_error=0.
- Back-to-back: write 0x200/0x11111111, write 0x204/0x22222222, read 0x200, each HREADY=1 -> HADDR advances every cycle; HWDATA=0x11111111 then 0x22222222 one cycle behind HADDR; 3 responses on consecutive cycles, the read returning 0x11111111.
- Wait states: read 0x300 with HREADY=0 for 3 cycles, a second request pending -> HADDR/HTRANS/HWDATA stable and req_ready=0 during the waits; rsp arrives 3 cycles later than the zero-wait case.
- ERROR: write 0x400 then read 0x404 queued; slave returns HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> HTRANS=IDLE in cycle 2; rsp_error=1 for 0x400, then rsp_error=1 for 0x404 the next cycle; no NONSEQ to 0x404; req_ready=0 for both error cycles.
- Reset mid-operation: assert HRESET during a wait state of read 0x500 -> same cycle HTRANS=IDLE, HADDR=0, rsp_valid=0; after deassert a new read 0x600 completes normally.
- Width: DATA_W=64, req_size=3, wdata 0x0123456789ABCDEF -> HSIZE=3'b011; full 64-bit HWDATA driven.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the request record used by bus masters.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'b000,
    SIZE_HALF  = 3'b001,
    SIZE_WORD  = 3'b010,
    SIZE_DWORD = 3'b011
  } hsize_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 64;
  localparam int REQ_SIZE_W = 3;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_SIZE_W-1:0] size;
    logic [REQ_DATA_W-1:0] wdata;
  } ahb_req_t;

endpackage

// File: rtl/ahb_lite_master_pipe.sv
// Pipelined AHB-Lite master: address stage (_p0) overlaps data stage (_p1),
// single NONSEQ transfers, in-order responses, two-cycle ERROR handling.
module ahb_lite_master_pipe
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 3
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [SIZE_W-1:0] req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [SIZE_W-1:0] HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  logic              vld_p0;
  logic              cancel_p0;
  logic              write_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [SIZE_W-1:0] size_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              vld_p1;
  logic              write_p1;
  logic [DATA_W-1:0] wdata_p1;

  logic              err_pend;
  logic              accept;
  logic              resp_err;
  logic              err_first;
  logic              err_second;
  logic              advance;

  assign resp_err   = (HRESP == RESP_ERROR);
  assign req_ready  = (!vld_p0 || HREADY) && !err_pend;
  assign accept     = req_valid && req_ready;
  assign err_first  = vld_p1 && resp_err && !HREADY;
  assign err_second = err_pend && HREADY;
  assign advance    = HREADY && !err_pend;

  assign HTRANS = (vld_p0 && !cancel_p0) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR  = addr_p0;
  assign HWRITE = write_p0;
  assign HSIZE  = size_p0;
  assign HWDATA = wdata_p1;

  // Control: stage valids, cancel, error tracking and the response pulse
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      vld_p0    <= 1'b0;
      cancel_p0 <= 1'b0;
      vld_p1    <= 1'b0;
      err_pend  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
      if (err_second) begin
        rsp_valid <= cancel_p0;
        rsp_error <= cancel_p0;
        vld_p0    <= 1'b0;
        cancel_p0 <= 1'b0;
        err_pend  <= 1'b0;
      end else if (err_first) begin
        rsp_valid <= 1'b1;
        rsp_error <= 1'b1;
        vld_p1    <= 1'b0;
        err_pend  <= 1'b1;
        // a request taken into an empty A on this edge is cancelled as well
        vld_p0    <= vld_p0 || accept;
        cancel_p0 <= vld_p0 || accept;
      end else if (advance) begin
        if (vld_p1) begin
          rsp_valid <= 1'b1;
          rsp_error <= resp_err;
          rsp_rdata <= (write_p1 || resp_err) ? '0 : HRDATA;
        end
        vld_p1 <= vld_p0;
        vld_p0 <= accept;
      end else if (accept) begin
        vld_p0 <= 1'b1;
      end
    end
  end

  // Stage A payload: loaded only when a request is accepted
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      write_p0 <= 1'b0;
      addr_p0  <= '0;
      size_p0  <= '0;
      wdata_p0 <= '0;
    end else if (accept) begin
      write_p0 <= req_write;
      addr_p0  <= req_addr;
      size_p0  <= req_size;
      wdata_p0 <= req_wdata;
    end
  end

  // Stage D payload: follows A on each completed address phase, holds in waits
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      write_p1 <= 1'b0;
      wdata_p1 <= '0;
    end else if (advance) begin
      write_p1 <= write_p0;
      wdata_p1 <= wdata_p0;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_pipe.sv
// Bench for ahb_lite_master_pipe: cycle table, reset/width sequences and a
// randomized run against a memory-level reference model.
module tb_ahb_lite_master_pipe;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TN = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_error;
  logic [63:0] rsp_rdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [63:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  int checks = 0;
  int errors = 0;

  ahb_lite_master_pipe #(.ADDR_W(32), .DATA_W(64), .SIZE_W(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        rv, rw;
    logic [31:0] ra;
    logic [63:0] rwd;
    logic        hr, hresp;
    logic [63:0] hrd;
    logic [1:0]  e_tr;
    logic [31:0] e_addr;
    logic        chk_wd;
    logic [63:0] e_wd;
    logic        e_rdy, e_rv, e_rerr;
    logic [63:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rv, rw, input logic [31:0] ra, input logic [63:0] rwd,
                     input logic hr, hresp, input logic [63:0] hrd,
                     input logic [1:0] e_tr, input logic [31:0] e_addr,
                     input logic chk_wd, input logic [63:0] e_wd,
                     input logic e_rdy, e_rv, e_rerr, input logic [63:0] e_rd);
    vec_t v;
    v = '{rv, rw, ra, rwd, hr, hresp, hrd, e_tr, e_addr, chk_wd, e_wd, e_rdy, e_rv, e_rerr, e_rd};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = 3'd2; req_wdata = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
  endtask

  // reference memory (request-order semantics) and slave memory
  logic [63:0] ref_mem [logic [31:0]];
  logic [63:0] slv_mem [logic [31:0]];
  logic [63:0] exp_q[$];

  function automatic logic [63:0] init_val(input logic [31:0] a);
    return {32'h0, a ^ 32'h5A5A_0000};
  endfunction

  initial begin
    logic        pv, pw, dp_v, dp_w;
    logic [31:0] pa, dp_a;
    logic [63:0] pd, e;
    int          nresp;

    HRESET = 1'b1;
    idle_inputs();
    step(); step();
    chk("rst_htrans", 0, HTRANS, TI);
    chk("rst_haddr", 0, HADDR, 0);
    chk("rst_hwrite", 0, HWRITE, 0);
    chk("rst_hsize", 0, HSIZE, 0);
    chk("rst_hwdata", 0, HWDATA, 0);
    chk("rst_rsp_valid", 0, rsp_valid, 0);
    chk("rst_rsp_rdata", 0, rsp_rdata, 0);
    chk("rst_rsp_error", 0, rsp_error, 0);
    chk("rst_req_ready", 0, req_ready, 1);
    HRESET = 1'b0;
    step();

    // read zero-wait, back-to-back, wait states, ERROR
    add(1,0,'h100,0,                   1,0,0,            TI,0,      0,0,           1,0,0,0);
    add(0,0,0,0,                       1,0,0,            TN,'h100,  0,0,           1,0,0,0);
    add(0,0,0,0,                       1,0,'hDEADBEEF,   TI,0,      0,0,           1,0,0,0);
    add(1,1,'h200,'h11111111,          1,0,0,            TI,0,      0,0,           1,1,0,'hDEADBEEF);
    add(1,1,'h204,'h22222222,          1,0,0,            TN,'h200,  0,0,           1,0,0,0);
    add(1,0,'h200,0,                   1,0,0,            TN,'h204,  1,'h11111111,  1,0,0,0);
    add(0,0,0,0,                       1,0,0,            TN,'h200,  1,'h22222222,  1,1,0,0);
    add(0,0,0,0,                       1,0,'h11111111,   TI,0,      0,0,           1,1,0,0);
    add(1,0,'h300,'h33333333,          1,0,0,            TI,0,      0,0,           1,1,0,'h11111111);
    add(1,0,'h304,0,                   1,0,0,            TN,'h300,  0,0,           1,0,0,0);
    add(1,0,'h308,0,                   0,0,0,            TN,'h304,  1,'h33333333,  0,0,0,0);
    add(1,0,'h308,0,                   0,0,0,            TN,'h304,  1,'h33333333,  0,0,0,0);
    add(1,0,'h308,0,                   0,0,0,            TN,'h304,  1,'h33333333,  0,0,0,0);
    add(1,0,'h308,0,                   1,0,'hA0A00300,   TN,'h304,  1,'h33333333,  1,0,0,0);
    add(0,0,0,0,                       1,0,'hA0A00304,   TN,'h308,  1,0,           1,1,0,'hA0A00300);
    add(0,0,0,0,                       1,0,'hA0A00308,   TI,0,      0,0,           1,1,0,'hA0A00304);
    add(1,1,'h400,'h44444444,          1,0,0,            TI,0,      0,0,           1,1,0,'hA0A00308);
    add(1,0,'h404,0,                   1,0,0,            TN,'h400,  0,0,           1,0,0,0);
    add(1,0,'h408,0,                   0,1,'hFFFF,       TN,'h404,  1,'h44444444,  0,0,0,0);
    add(1,0,'h408,0,                   1,1,'hFFFF,       TI,0,      0,0,           0,1,1,0);
    add(1,0,'h408,0,                   1,0,0,            TI,0,      0,0,           1,1,1,0);
    add(0,0,0,0,                       1,0,0,            TN,'h408,  0,0,           1,0,0,0);
    add(0,0,0,0,                       1,0,'hB0B00408,   TI,0,      0,0,           1,0,0,0);
    add(0,0,0,0,                       1,0,0,            TI,0,      0,0,           1,1,0,'hB0B00408);

    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].rv; req_write = tbl[i].rw; req_addr = tbl[i].ra;
      req_wdata = tbl[i].rwd; req_size = 3'd2;
      HREADY = tbl[i].hr; HRESP = tbl[i].hresp; HRDATA = tbl[i].hrd;
      #1;
      chk("htrans", i, HTRANS, tbl[i].e_tr);
      if (tbl[i].e_tr == TN) chk("haddr", i, HADDR, tbl[i].e_addr);
      if (tbl[i].chk_wd) chk("hwdata", i, HWDATA, tbl[i].e_wd);
      chk("req_ready", i, req_ready, tbl[i].e_rdy);
      chk("rsp_valid", i, rsp_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) begin
        chk("rsp_error", i, rsp_error, tbl[i].e_rerr);
        chk("rsp_rdata", i, rsp_rdata, tbl[i].e_rd);
      end
      step();
    end

    // reset during a wait state of read 0x500 (0x504 waiting in address phase)
    idle_inputs();
    req_valid = 1'b1; req_addr = 'h500;
    step();
    req_addr = 'h504;
    #1;
    chk("mid_haddr_500", 0, HADDR, 'h500);
    step();
    req_valid = 1'b0; HREADY = 1'b0;
    #1;
    chk("mid_haddr_504", 0, HADDR, 'h504);
    #2;
    HRESET = 1'b1;
    #1;
    chk("mid_rst_htrans", 0, HTRANS, TI);
    chk("mid_rst_haddr", 0, HADDR, 0);
    chk("mid_rst_rsp_valid", 0, rsp_valid, 0);
    chk("mid_rst_req_ready", 0, req_ready, 1);
    HREADY = 1'b1;
    step(); step();
    #2;
    HRESET = 1'b0;
    step();
    req_valid = 1'b1; req_addr = 'h600;
    #1;
    chk("post_rst_ready", 0, req_ready, 1);
    step();
    req_valid = 1'b0;
    #1;
    chk("post_rst_htrans", 1, HTRANS, TN);
    chk("post_rst_haddr", 1, HADDR, 'h600);
    chk("post_rst_rsp_valid", 1, rsp_valid, 0);
    step();
    HRDATA = 'h66006600;
    #1;
    chk("post_rst_rsp_valid", 2, rsp_valid, 0);
    step();
    HRDATA = '0;
    chk("post_rst_rsp_valid", 3, rsp_valid, 1);
    chk("post_rst_rsp_rdata", 3, rsp_rdata, 'h66006600);
    chk("post_rst_rsp_error", 3, rsp_error, 0);
    step();
    chk("post_rst_rsp_valid", 4, rsp_valid, 0);

    // full 64-bit doubleword write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 'h700; req_size = 3'd3;
    req_wdata = 64'h0123_4567_89AB_CDEF;
    step();
    req_valid = 1'b0;
    #1;
    chk("w64_htrans", 0, HTRANS, TN);
    chk("w64_hsize", 0, HSIZE, 3'b011);
    chk("w64_hwrite", 0, HWRITE, 1);
    step();
    chk("w64_hwdata", 0, HWDATA, 64'h0123_4567_89AB_CDEF);
    step();
    chk("w64_rsp_valid", 0, rsp_valid, 1);
    chk("w64_rsp_rdata", 0, rsp_rdata, 0);
    idle_inputs();
    step();

    // randomized traffic with random wait states against a memory slave
    pv = 1'b0; pw = 1'b0; pa = '0; pd = '0;
    dp_v = 1'b0; dp_w = 1'b0; dp_a = '0;
    nresp = 0;
    for (int i = 0; i < 460; i++) begin
      if (!pv && i < 400 && $urandom_range(0, 3) != 0) begin
        pv = 1'b1;
        pw = 1'($urandom_range(0, 1));
        pa = 32'h800 + 32'(4 * $urandom_range(0, 7));
        pd = {32'h0, $urandom};
      end
      if (i >= 400 && !pv && exp_q.size() == 0) break;
      req_valid = pv; req_write = pw; req_addr = pa; req_wdata = pd; req_size = 3'd2;
      HREADY = ($urandom_range(0, 3) != 0);
      HRESP = 1'b0;
      if (dp_v && !dp_w)
        HRDATA = slv_mem.exists(dp_a) ? slv_mem[dp_a] : init_val(dp_a);
      else
        HRDATA = {$urandom, $urandom};
      #1;
      if (rsp_valid) begin
        nresp++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_extra_rsp[%0d]: got rsp_valid=1, want no response", i);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_rdata", i, rsp_rdata, e);
          chk("rnd_error", i, rsp_error, 0);
        end
      end
      if (req_valid && req_ready) begin
        if (pw) begin
          ref_mem[pa] = pd;
          exp_q.push_back('0);
        end else begin
          exp_q.push_back(ref_mem.exists(pa) ? ref_mem[pa] : init_val(pa));
        end
        pv = 1'b0;
      end
      if (HREADY) begin
        if (dp_v && dp_w) slv_mem[dp_a] = HWDATA;
        dp_v = (HTRANS == TN);
        dp_w = HWRITE;
        dp_a = HADDR;
      end
      step();
    end
    chk("rnd_drain_queue", 0, exp_q.size(), 0);
    chk("rnd_drain_pending", 0, pv, 0);
    if (nresp == 0) begin
      checks++; errors++;
      $display("FAIL rnd_no_responses: got 0 responses, want at least 1");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
